// File: rtl/step_sequencer_pkg.sv
// narvie_pkg: shared types and constants for the interactive step sequencer.
//   seq_state_t      - controller states
//   NOP_INST_DEFAULT - filler instruction (addi x0,x0,0)
//   REG_BYTES        - bytes in one register-file dump (32 regs x 4 bytes)
//   REGFILE_W        - width of the flattened register file
package narvie_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    STEP_SET,
    STEP_PULSE,
    CAPTURE,
    SEND
  } seq_state_t;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam int          REG_BYTES        = 128;
  localparam int          REGFILE_W        = 1024;

endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: byte-level link between the UART front-end and the
// step sequencer.
//   rx_data/rx_valid  - received byte and its one-cycle strobe
//   tx_data/tx_valid  - byte offered to the transmitter, held until accepted
//   tx_ready          - transmitter accepts when tx_valid && tx_ready
// Modports: master = UART front-end side, slave = step sequencer side.
interface step_sequencer_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/step_sequencer_serializer.sv
// regfile_serializer: snapshots the register file and streams it out as
// REG_BYTES bytes over a valid/ready handshake, x0 first, each register LSB
// first.
//   clk, reset  - system clock, synchronous active-high reset
//   start       - one-cycle pulse: latch regfile, restart at byte 0
//   regfile     - flattened x0..x31
//   tx_data     - current byte of the snapshot
//   tx_valid    - byte pending; held until accepted
//   tx_ready    - transmitter acceptance
//   done        - one-cycle pulse on acceptance of the last byte
module regfile_serializer
  import narvie_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [REGFILE_W-1:0] regfile,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done
);

  localparam logic [6:0] LAST_IDX = 7'(REG_BYTES - 1);

  logic [REGFILE_W-1:0] snapshot;
  logic [6:0]           idx;
  logic                 accept;

  assign accept = tx_valid && tx_ready;
  assign done   = accept && (idx == LAST_IDX);

  // idx wraps back to 0 on the final acceptance, so a fresh start always
  // begins at byte 0 even without the explicit clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (start) begin
      snapshot <= regfile;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (accept) begin
      idx <= idx + 7'd1;
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    tx_data = snapshot[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: runs one interactive processor step. Collects a 32-bit
// instruction (4 bytes, little-endian) from the UART, issues it followed by
// PIPE_STEPS-1 NOPs as single-cycle step enables, then dumps the register
// file back over the UART.
//   clk, reset  - system clock, synchronous active-high reset
//   uart        - step_sequencer_if slave: rx bytes in, tx bytes out
//   regfile     - flattened x0..x31 from the CPU
//   inst_out    - instruction presented to the CPU
//   proc_step   - one-cycle CPU advance enable
//   busy        - high whenever not IDLE
//   overrun     - sticky: a byte arrived while not accepting bytes
module step_sequencer
  import narvie_pkg::*;
#(
  parameter int          PIPE_STEPS = 5,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  step_sequencer_if.slave      uart,
  input  logic [REGFILE_W-1:0] regfile,
  output logic [31:0]          inst_out,
  output logic                 proc_step,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [3:0] STEP_TOTAL = 4'(PIPE_STEPS);

  seq_state_t state;
  seq_state_t next_state;

  logic [31:0] inst;
  logic [1:0]  byte_cnt;
  logic [3:0]  step_cnt;
  logic        ser_start;
  logic        ser_done;
  logic        rx_blocked;

  // Bytes are only welcome while assembling an instruction.
  assign rx_blocked = (state == STEP_SET) || (state == STEP_PULSE) ||
                      (state == CAPTURE)  || (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (uart.rx_valid) next_state = RECV;
      RECV:       if (uart.rx_valid && (byte_cnt == 2'd3)) next_state = STEP_SET;
      STEP_SET:   next_state = STEP_PULSE;
      STEP_PULSE: next_state = ((step_cnt + 4'd1) == STEP_TOTAL) ? CAPTURE : STEP_SET;
      CAPTURE:    next_state = SEND;
      SEND:       if (ser_done) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Instruction assembly, step counting and the sticky overrun flag. The byte
  // counter wraps to 0 on the 4th byte, which is exactly what the next
  // instruction needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst     <= '0;
      byte_cnt <= '0;
      step_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (uart.rx_valid) begin
            inst[7:0] <= uart.rx_data;
            byte_cnt  <= 2'd1;
          end
        end
        RECV: begin
          if (uart.rx_valid) begin
            inst[{byte_cnt, 3'b000} +: 8] <= uart.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              step_cnt <= '0;
            end
          end
        end
        STEP_PULSE: begin
          step_cnt <= step_cnt + 4'd1;
        end
        default: begin
        end
      endcase
      if (uart.rx_valid && rx_blocked) begin
        overrun <= 1'b1;
      end
    end
  end

  // inst_out is decoded from state so it is stable for the whole STEP_SET
  // cycle and the following pulse; step_cnt only moves at the end of a pulse.
  always_comb begin
    inst_out  = NOP_INST;
    proc_step = 1'b0;
    ser_start = 1'b0;
    busy      = (state != IDLE);
    case (state)
      STEP_SET: begin
        if (step_cnt == 4'd0) inst_out = inst;
      end
      STEP_PULSE: begin
        if (step_cnt == 4'd0) inst_out = inst;
        proc_step = 1'b1;
      end
      CAPTURE: begin
        ser_start = 1'b1;
      end
      default: begin
      end
    endcase
  end

  regfile_serializer u_serializer (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .regfile  (regfile),
    .tx_data  (uart.tx_data),
    .tx_valid (uart.tx_valid),
    .tx_ready (uart.tx_ready),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: self-checking bench for step_sequencer. A timing-based
// reference model (cycle of the 4th byte, send progress) predicts every
// output each cycle; a monitor records pulses and transmitted bytes for a
// few hand-computed literal checks.
module tb_step_sequencer;

  localparam int          P   = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                             clk = 1'b0;
  logic                             reset = 1'b1;
  logic [narvie_pkg::REGFILE_W-1:0] regfile = '0;
  logic [31:0]                      inst_out;
  logic                             proc_step;
  logic                             busy;
  logic                             overrun;

  step_sequencer_if uart ();

  step_sequencer #(.PIPE_STEPS(P), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart      (uart.slave),
    .regfile   (regfile),
    .inst_out  (inst_out),
    .proc_step (proc_step),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model state
  bit                               model_ok = 0;
  int                               t4 = -1;
  int                               last_t4 = 0;
  logic [31:0]                      word = '0;
  bit                               sending = 0;
  int                               sent = 0;
  logic [narvie_pkg::REGFILE_W-1:0] snap = '0;
  bit                               ovr = 0;
  logic [7:0]                       rxq[$];

  // Monitor records
  int          pulse_cyc[$];
  logic [31:0] pulse_inst[$];
  logic [7:0]  got[$];
  int          valid_rise = 0;
  int          valid_fall = 0;

  // Stimulus controls
  int ready_mode = 0;
  bit rf_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter readiness and (optionally) a register file that changes
  // every cycle, so the snapshot moment is pinned.
  initial begin : ready_driver
    int phase3;
    phase3 = 0;
    uart.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: uart.tx_ready = 1'b1;
        1: begin
          uart.tx_ready = (phase3 == 0);
          phase3 = (phase3 + 1) % 3;
        end
        default: uart.tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (rf_rand) begin
        for (int i = 0; i < 32; i++) regfile[32*i +: 32] = $urandom();
      end
    end
  end

  // Compare, monitor, then advance the model with this cycle's inputs.
  initial begin : compare_proc
    bit          exec, exp_step, exp_busy, was_exec, was_send;
    int          d;
    logic [31:0] exp_inst;
    logic        prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      exec = (t4 >= 0);
      d = cyc - t4;
      if (model_ok) begin
        exp_step = exec && (d >= 2) && (d <= 2*P) && (d % 2 == 0);
        exp_inst = (exec && (d == 1 || d == 2)) ? word : NOP;
        exp_busy = (rxq.size() != 0) || exec || sending;
        check("proc_step", proc_step, exp_step);
        check("inst_out", inst_out, exp_inst);
        check("busy", busy, exp_busy);
        check("overrun", overrun, ovr);
        check("tx_valid", uart.tx_valid, sending);
        if (sending) check("tx_data", uart.tx_data, snap[8*sent +: 8]);
      end
      if (proc_step === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_inst.push_back(inst_out);
      end
      if (uart.tx_valid === 1'b1 && uart.tx_ready === 1'b1) got.push_back(uart.tx_data);
      if (uart.tx_valid === 1'b1 && prev_valid !== 1'b1) valid_rise = cyc;
      if (uart.tx_valid !== 1'b1 && prev_valid === 1'b1) valid_fall = cyc;
      prev_valid = uart.tx_valid;
      was_exec = exec;
      was_send = sending;
      if (reset) begin
        model_ok = 1;
        t4 = -1;
        sending = 0;
        sent = 0;
        snap = '0;
        ovr = 0;
        rxq.delete();
      end else if (model_ok) begin
        if (was_send && uart.tx_ready) begin
          sent++;
          if (sent == 128) begin
            sending = 0;
            sent = 0;
          end
        end
        if (was_exec && d == 2*P + 1) begin
          snap = regfile;
          sending = 1;
          sent = 0;
          t4 = -1;
        end
        if (uart.rx_valid) begin
          if (was_exec || was_send) ovr = 1;
          else begin
            rxq.push_back(uart.rx_data);
            if (rxq.size() == 4) begin
              word = {rxq[3], rxq[2], rxq[1], rxq[0]};
              t4 = cyc;
              last_t4 = cyc;
              rxq.delete();
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    uart.rx_valid = 1'b1;
    uart.rx_data  = b;
    tick();
    uart.rx_valid = 1'b0;
  endtask

  task automatic send_inst(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(w[8*i +: 8]);
      if (i < 3) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_inst.delete();
    got.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((t4 >= 0 || sending) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", (n >= budget), 1'b0);
    tick();
    tick();
  endtask

  task automatic check_output(input int exp_pulses, input logic [31:0] exp_first);
    check("pulse_count", pulse_inst.size(), exp_pulses);
    if (pulse_inst.size() > 0) check("first_pulse_inst", pulse_inst[0], exp_first);
    check("byte_count", got.size(), 128);
  endtask

  initial begin : main
    int n;
    uart.rx_valid = 1'b0;
    uart.rx_data  = '0;
    tick();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_inst_out", inst_out, NOP);
    check("rst_proc_step", proc_step, 1'b0);
    check("rst_tx_valid", uart.tx_valid, 1'b0);
    check("rst_tx_data", uart.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    repeat (2) tick();

    // addi x1,x0,5 with x1 already holding 5 in the supplied register file
    clear_mon();
    ready_mode = 0;
    rf_rand = 0;
    regfile = '0;
    for (int i = 2; i < 32; i++) regfile[32*i +: 32] = $urandom();
    regfile[63:32] = 32'd5;
    send_inst(32'h0050_0093, 0);
    wait_idle(400);
    check_output(5, 32'h0050_0093);
    if (pulse_inst.size() == 5) check("last_pulse_inst", pulse_inst[4], 32'h0000_0013);
    for (int k = 0; k < 5; k++) begin
      if (k < pulse_cyc.size()) check("pulse_time", pulse_cyc[k] - last_t4, 2*(k+1));
    end
    check("tx_valid_rise", valid_rise - last_t4, 12);
    check("tx_valid_fall", valid_fall - last_t4, 140);
    if (got.size() == 128) begin
      for (int i = 0; i < 8; i++) check("dump_byte", got[i], (i == 4) ? 8'h05 : 8'h00);
    end

    // Slow transmitter, register file changing every cycle
    clear_mon();
    ready_mode = 1;
    rf_rand = 1;
    send_inst($urandom(), 2);
    wait_idle(600);
    check_output(5, word);

    // Byte during SEND is dropped and flagged; next instruction still runs
    clear_mon();
    ready_mode = 0;
    send_inst(32'h0010_0113, 0);
    n = 0;
    while (uart.tx_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("send_start_timeout", (n >= 100), 1'b0);
    repeat (20) tick();
    apply_stimulus(8'hAA);
    wait_idle(400);
    check("overrun_set", overrun, 1'b1);
    check_output(5, 32'h0010_0113);
    clear_mon();
    send_inst(32'h0020_0193, 1);
    wait_idle(400);
    check_output(5, 32'h0020_0193);
    check("overrun_sticky", overrun, 1'b1);

    // Reset mid-RECV discards the partial instruction
    apply_stimulus(8'h77);
    apply_stimulus(8'h66);
    tick();
    pulse_reset();
    clear_mon();
    send_inst(32'h0000_0013, 0);
    wait_idle(400);
    check_output(5, 32'h0000_0013);
    check("overrun_cleared", overrun, 1'b0);

    // Reset at byte 60 of SEND
    clear_mon();
    send_inst($urandom(), 0);
    n = 0;
    while (got.size() < 60 && n < 300) begin
      tick();
      n++;
    end
    check("idx60_timeout", (n >= 300), 1'b0);
    pulse_reset();
    check("post_rst_tx_valid", uart.tx_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    clear_mon();
    repeat (20) tick();
    check("no_pulse_after_rst", pulse_inst.size(), 0);

    // Randomized transactions with stray bytes and a random transmitter
    for (int t = 0; t < 8; t++) begin
      clear_mon();
      ready_mode = 2;
      send_inst($urandom(), 3);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 15)) tick();
        apply_stimulus(8'($urandom()));
      end
      wait_idle(2000);
      check_output(5, word);
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
